// File: rtl/booth_multiplier_if.sv
// booth_multiplier_if
//   Start/done handshake and operand/result bus between the execution
//   sequencer (master) and the radix-4 multiplier (slave).
//   All vectors are declared MSB-first with bit 0 as the MSB.
//
//   start        master -> slave  request, sampled only while the unit is idle
//   signed_mode  master -> slave  1 = two's-complement operands, 0 = unsigned
//   multiplier   master -> slave  operand A (WIDTH bits)
//   multiplicand master -> slave  operand B (WIDTH bits), recoded in bit pairs
//   result       slave -> master  2*WIDTH-bit product, held until next completion
//   overflow     slave -> master  product does not fit in WIDTH bits
//   done         slave -> master  high when idle with a valid result
interface booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_mode;
    logic [0:WIDTH-1]       multiplier;
    logic [0:WIDTH-1]       multiplicand;
    logic [0:2*WIDTH-1]     result;
    logic                   overflow;
    logic                   done;

    modport master (
        output start,
        output signed_mode,
        output multiplier,
        output multiplicand,
        input  result,
        input  overflow,
        input  done
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  multiplier,
        input  multiplicand,
        output result,
        output overflow,
        output done
    );
endinterface

// File: rtl/booth_multiplier.sv
// booth_multiplier
//   Radix-4 (bit-pair) sequential multiplier, unsigned or two's-complement.
//   Fixed latency: capture edge, WIDTH/2+1 iteration edges, one result edge.
//
//   clock  rising-edge clock
//   reset  asynchronous, active-high; aborts any operation in flight
//   bus    booth_multiplier_if slave port (start, signed_mode, multiplier,
//          multiplicand in; result, overflow, done out, all registered)
//
//   The multiplicand is recoded two bits at a time with a carry into the
//   next pair: pair+carry of 0,1,2 give 0,+C,+2C; 3 gives -C with carry;
//   4 gives 0 with carry. The multiplicand is extended by one extra pair
//   (zero or sign bits) so the final carry is always absorbed; in signed
//   mode the carry out of that extra pair exactly cancels the wrap of the
//   extended value and is dropped.
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    booth_multiplier_if.slave   bus
);

    localparam int PAIRS = WIDTH / 2 + 1;          // iteration cycles
    localparam int ACC_W = WIDTH + 4;              // accumulator with headroom for +2C and -C
    localparam int LOW_W = WIDTH + 2;              // extended multiplicand / low product bits
    localparam int P_W   = ACC_W + LOW_W;
    localparam int CNT_W = $clog2(PAIRS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        RESULT
    } state_t;

    typedef enum logic [1:0] {
        PP_ZERO,
        PP_POS,
        PP_POS2,
        PP_NEG
    } pp_t;

    typedef struct packed {
        logic carry;
        pp_t  pp;
    } recode_t;

    // Bit-pair recode with carry in from the previous (less significant) pair.
    function automatic recode_t recode(input logic [1:0] pair, input logic carry_in);
        recode_t    r;
        logic [2:0] v;
        v = {1'b0, pair} + {2'b00, carry_in};
        case (v)
            3'd0:    begin r.carry = 1'b0; r.pp = PP_ZERO; end
            3'd1:    begin r.carry = 1'b0; r.pp = PP_POS;  end
            3'd2:    begin r.carry = 1'b0; r.pp = PP_POS2; end
            3'd3:    begin r.carry = 1'b1; r.pp = PP_NEG;  end
            default: begin r.carry = 1'b1; r.pp = PP_ZERO; end
        endcase
        return r;
    endfunction

    // Registers
    state_t                 state_q,    state_d;
    logic [ACC_W-1:0]       acc_q,      acc_d;
    logic [LOW_W-1:0]       low_q,      low_d;
    logic [ACC_W-1:0]       c_q,        c_d;
    pp_t                    pp_q,       pp_d;
    logic                   carry_q,    carry_d;
    logic [CNT_W-1:0]       count_q,    count_d;
    logic                   signed_q,   signed_d;
    logic [2*WIDTH-1:0]     result_q,   result_d;
    logic                   overflow_q, overflow_d;
    logic                   done_q,     done_d;

    // Datapath
    logic [WIDTH-1:0]       mplier;
    logic [WIDTH-1:0]       mcand;
    logic                   ext_a;
    logic                   ext_b;
    recode_t                capture_rec;
    recode_t                iter_rec;
    logic [ACC_W-1:0]       addend;
    logic [ACC_W-1:0]       sum;
    logic [P_W-1:0]         shifted;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH:0]         upper_signed;
    logic [WIDTH-1:0]       upper_unsigned;
    logic                   ovf_signed;
    logic                   ovf_unsigned;

    // Port vectors are MSB-first; plain assignment keeps numeric value.
    assign mplier = bus.multiplier;
    assign mcand  = bus.multiplicand;

    assign ext_a = bus.signed_mode & mplier[WIDTH-1];
    assign ext_b = bus.signed_mode & mcand[WIDTH-1];

    assign capture_rec = recode(mcand[1:0], 1'b0);
    // low_q[3:2] become low_q[1:0] after this cycle's shift, i.e. next pair.
    assign iter_rec    = recode(low_q[3:2], carry_q);

    always_comb begin
        addend = '0;
        case (pp_q)
            PP_ZERO: addend = '0;
            PP_POS:  addend = c_q;
            PP_POS2: addend = {c_q[ACC_W-2:0], 1'b0};
            PP_NEG:  addend = ~c_q;
            default: addend = '0;
        endcase
    end

    // -C is formed as ~C plus a carry-in of one.
    assign sum = acc_q + addend + {{(ACC_W-1){1'b0}}, (pp_q == PP_NEG)};

    // Partial sums can go transiently negative even for unsigned operands
    // (a -C digit is waiting for its +4C carry), so the wide accumulator is
    // always shifted arithmetically. Unsigned operands are zero-extended into
    // it, which makes this equivalent to a logical shift of the true value.
    assign shifted = $signed({sum, low_q}) >>> 2;

    // After all pairs, {acc, low} holds the exact product; keep 2*WIDTH bits.
    assign prod = {acc_q[WIDTH-3:0], low_q};

    assign upper_signed   = prod[2*WIDTH-1:WIDTH-1];
    assign upper_unsigned = prod[2*WIDTH-1:WIDTH];
    assign ovf_signed     = !((&upper_signed) || !(|upper_signed));
    assign ovf_unsigned   = |upper_unsigned;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        low_d      = low_q;
        c_d        = c_q;
        pp_d       = pp_q;
        carry_d    = carry_q;
        count_d    = count_q;
        signed_d   = signed_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = done_q;

        case (state_q)
            IDLE: begin
                done_d = 1'b1;
                if (bus.start) begin
                    signed_d = bus.signed_mode;
                    c_d      = {{(ACC_W-WIDTH){ext_a}}, mplier};
                    low_d    = {ext_b, ext_b, mcand};
                    acc_d    = '0;
                    pp_d     = capture_rec.pp;
                    carry_d  = capture_rec.carry;
                    count_d  = CNT_W'(PAIRS);
                    done_d   = 1'b0;
                    state_d  = ITER;
                end
            end

            ITER: begin
                acc_d   = shifted[P_W-1:LOW_W];
                low_d   = shifted[LOW_W-1:0];
                pp_d    = iter_rec.pp;
                carry_d = iter_rec.carry;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = RESULT;
                end
            end

            RESULT: begin
                result_d   = prod;
                overflow_d = signed_q ? ovf_signed : ovf_unsigned;
                done_d     = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            low_q      <= '0;
            c_q        <= '0;
            pp_q       <= PP_ZERO;
            carry_q    <= 1'b0;
            count_q    <= '0;
            signed_q   <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            low_q      <= low_d;
            c_q        <= c_d;
            pp_q       <= pp_d;
            carry_q    <= carry_d;
            count_q    <= count_d;
            signed_q   <= signed_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier
//   Drives a WIDTH=32 and a WIDTH=8 instance and checks products, overflow
//   flags, latency and handshake behaviour against an arithmetic model.
module tb_booth_multiplier;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    booth_multiplier_if #(.WIDTH(32)) bus32 ();
    booth_multiplier_if #(.WIDTH(8))  bus8 ();

    booth_multiplier #(.WIDTH(32)) dut32 (
        .clock (clock),
        .reset (reset),
        .bus   (bus32.slave)
    );

    booth_multiplier #(.WIDTH(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] last_exp32 = '0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed === expected)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Product of w-bit operands as exact integers, reduced to 2w bits.
    function automatic void golden(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input bit sm, output logic [63:0] prod, output logic ov);
        logic [127:0]        one;
        logic signed [127:0] av, bv, full, lim;
        one = 128'd1;
        av  = $signed({96'd0, a});
        bv  = $signed({96'd0, b});
        if (sm) begin
            if (a[w-1]) av = av - $signed(one << w);
            if (b[w-1]) bv = bv - $signed(one << w);
        end
        full = av * bv;
        if (sm) begin
            lim = $signed(one << (w - 1));
            ov  = (full < -lim) || (full >= lim);
        end else begin
            ov  = full >= $signed(one << w);
        end
        prod = full[63:0];
        if (w < 32) prod = prod & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [31:0] pick32();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return 32'($urandom);
    endfunction

    function automatic logic [7:0] pick8();
        logic [7:0] corners [5];
        corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
        corners[3] = 8'h80; corners[4] = 8'hFF;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return 8'($urandom);
    endfunction

    // Called at a negedge with done high; returns at the negedge done rises.
    task automatic op32(input string tag, input bit sm, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ep;
        logic        eo;
        int          low;
        golden(32, a, b, sm, ep, eo);
        bus32.signed_mode  = sm;
        bus32.multiplier   = a;
        bus32.multiplicand = b;
        bus32.start        = 1'b1;
        @(negedge clock);
        bus32.start        = 1'b0;
        bus32.signed_mode  = 1'($urandom);
        bus32.multiplier   = 32'($urandom);
        bus32.multiplicand = 32'($urandom);
        low = 0;
        while (bus32.done !== 1'b1 && low < 40) begin
            if (low == 5) check({tag, " held"}, bus32.result, last_exp32);
            low++;
            @(negedge clock);
        end
        check({tag, " latency"}, 64'(low), 64'd18);
        check({tag, " result"}, bus32.result, ep);
        check({tag, " overflow"}, 64'(bus32.overflow), 64'(eo));
        last_exp32 = ep;
        $display("%s mode=%0d a=%h b=%h result=%h ovf=%0d", tag, sm, a, b, bus32.result, bus32.overflow);
    endtask

    initial begin
        int          low;
        logic [63:0] ep;
        logic        eo;
        logic [7:0]  a8, b8;
        bit          sm8;

        reset = 1'b1;
        bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.multiplier = '0; bus32.multiplicand = '0;
        bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.multiplier  = '0; bus8.multiplicand  = '0;
        repeat (2) @(negedge clock);
        check("reset done32", 64'(bus32.done), 64'd1);
        check("reset result32", bus32.result, 64'd0);
        check("reset ovf32", 64'(bus32.overflow), 64'd0);
        check("reset done8", 64'(bus8.done), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases from the arithmetic corners
        op32("u1x1", 1'b0, 32'd1, 32'd1);
        op32("u1x2", 1'b0, 32'd1, 32'd2);
        op32("u1x3", 1'b0, 32'd1, 32'd3);
        op32("u1x11", 1'b0, 32'd1, 32'd11);
        op32("u_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("u_ffxff const", last_exp32, 64'hFFFF_FFFE_0000_0001);
        op32("s_ffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op32("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7);
        check("s_m3x7 const", last_exp32, 64'hFFFF_FFFF_FFFF_FFEB);
        op32("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
        op32("s_minx1", 1'b1, 32'h8000_0000, 32'd1);

        for (int i = 0; i < 150; i++) begin
            op32($sformatf("r32_%0d", i), 1'($urandom), pick32(), pick32());
        end

        // Start pulses during ITER must be ignored and not queued
        bus32.signed_mode = 1'b0; bus32.multiplier = 32'd113; bus32.multiplicand = 32'd31415;
        bus32.start = 1'b1;
        @(negedge clock);
        bus32.start = 1'b0; bus32.multiplier = 32'd9999; bus32.multiplicand = 32'd7777;
        bus32.signed_mode = 1'b1;
        low = 0;
        while (bus32.done !== 1'b1 && low < 40) begin
            bus32.start = (low == 3 || low == 10 || low == 16);
            low++;
            @(negedge clock);
        end
        bus32.start = 1'b0;
        check("ignore latency", 64'(low), 64'd18);
        check("ignore result", bus32.result, 64'd3549895);
        low = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (bus32.done !== 1'b1) low++;
        end
        check("ignore no requeue", 64'(low), 64'd0);
        check("ignore result kept", bus32.result, 64'd3549895);
        $display("ignore_start result=%h", bus32.result);

        // Reset mid-operation
        bus32.signed_mode = 1'b0; bus32.multiplier = 32'hFFFF; bus32.multiplicand = 32'hFFFF;
        bus32.start = 1'b1;
        @(negedge clock);
        bus32.start = 1'b0;
        repeat (4) @(negedge clock);
        check("abort busy", 64'(bus32.done), 64'd0);
        reset = 1'b1;
        #1;
        check("abort done", 64'(bus32.done), 64'd1);
        check("abort result", bus32.result, 64'd0);
        check("abort ovf", 64'(bus32.overflow), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        check("abort idle", 64'(bus32.done), 64'd1);
        check("abort no result", bus32.result, 64'd0);
        $display("reset_abort done=%0d result=%h", bus32.done, bus32.result);
        last_exp32 = '0;

        // WIDTH=8 back-to-back with start held high
        bus8.start = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            a8  = pick8();
            b8  = pick8();
            sm8 = 1'($urandom);
            golden(8, {24'd0, a8}, {24'd0, b8}, sm8, ep, eo);
            bus8.signed_mode  = sm8;
            bus8.multiplier   = a8;
            bus8.multiplicand = b8;
            @(negedge clock);
            low = 0;
            while (bus8.done !== 1'b1 && low < 20) begin
                low++;
                @(negedge clock);
            end
            check($sformatf("w8_%0d latency", k), 64'(low), 64'd6);
            check($sformatf("w8_%0d result", k), 64'(bus8.result), ep);
            check($sformatf("w8_%0d overflow", k), 64'(bus8.overflow), 64'(eo));
            $display("w8_%0d mode=%0d a=%h b=%h result=%h ovf=%0d", k, sm8, a8, b8, bus8.result, bus8.overflow);
        end
        bus8.start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
